mem_access_unit: RTL and testbench

Load/store initiator sitting between the core's execute stage and the 32-bit data RAM. Accepts one LDR/LDRB/STR/STRB request at a time over a valid/ready handshake and drives the RAM port (byte-lane write enables, 18-bit byte address, read strobe). It absorbs the RAM's one-cycle registered read latency and returns a formatted 32-bit load result: byte zero-extension or ARM-style misaligned-word rotation.

---
 rtl/mem_access_pkg.sv | 34 +++
 rtl/mem_access_unit_load_formatter.sv | 29 ++
 rtl/mem_access_unit.sv | 139 +++++++++++++
 tb/tb_mem_access_unit.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the load/store initiator: FSM states, address
// geometry and byte-lane write-enable encodings.
package mem_access_pkg;

  localparam int ADDR_W    = 18;
  localparam int MEM_WORDS = 16384;

  // First byte address past the implemented RAM; anything at or above faults.
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_WORDS * 4);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [3:0] LANE_0 = 4'b0001;
  localparam logic [3:0] LANE_1 = 4'b0010;
  localparam logic [3:0] LANE_2 = 4'b0100;
  localparam logic [3:0] LANE_3 = 4'b1000;

  function automatic logic [3:0] lane_onehot(input logic [1:0] offset);
    logic [3:0] lanes;
    case (offset)
      2'd0:    lanes = LANE_0;
      2'd1:    lanes = LANE_1;
      2'd2:    lanes = LANE_2;
      default: lanes = LANE_3;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_formatter.sv
// Formats a raw RAM word into a load result: byte loads zero-extend the
// addressed lane, word loads rotate right so the addressed byte lands in [7:0].
module load_formatter (
  input  logic [31:0] mem_data,
  input  logic [1:0]  offset,
  input  logic        is_byte,
  output logic [31:0] fmt_data
);

  always_comb begin
    fmt_data = mem_data;
    if (is_byte) begin
      case (offset)
        2'd0:    fmt_data = {24'b0, mem_data[7:0]};
        2'd1:    fmt_data = {24'b0, mem_data[15:8]};
        2'd2:    fmt_data = {24'b0, mem_data[23:16]};
        default: fmt_data = {24'b0, mem_data[31:24]};
      endcase
    end else begin
      case (offset)
        2'd0:    fmt_data = mem_data;
        2'd1:    fmt_data = {mem_data[7:0],  mem_data[31:8]};
        2'd2:    fmt_data = {mem_data[15:0], mem_data[31:16]};
        default: fmt_data = {mem_data[23:0], mem_data[31:24]};
      endcase
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store initiator between execute and the data RAM.
// Every output is a flop or a decode of the state register.
module mem_access_unit
  import mem_access_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_isWrite,
  output logic [31:0]       mem_writeData,
  output logic              mem_isRead,
  output logic              mem_byteRead,
  input  logic [31:0]       mem_data
);

  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic              byte_q, byte_d;
  logic              fault_q, fault_d;
  logic [1:0]        offset_q, offset_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [3:0]        mem_is_write_q, mem_is_write_d;
  logic [31:0]       mem_write_data_q, mem_write_data_d;
  logic              mem_is_read_q, mem_is_read_d;
  logic              mem_byte_read_q, mem_byte_read_d;
  logic [31:0]       fmt_data;

  load_formatter u_load_formatter (
    .mem_data (mem_data),
    .offset   (offset_q),
    .is_byte  (byte_q),
    .fmt_data (fmt_data)
  );

  // RAM-side signals are computed on accept so they are already registered
  // during ISSUE; strobes fall back to zero every other cycle.
  always_comb begin
    state_d          = state_q;
    write_d          = write_q;
    byte_d           = byte_q;
    fault_d          = fault_q;
    offset_d         = offset_q;
    rdata_d          = rdata_q;
    mem_address_d    = mem_address_q;
    mem_write_data_d = mem_write_data_q;
    mem_is_write_d   = 4'b0000;
    mem_is_read_d    = 1'b0;
    mem_byte_read_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          byte_d   = req_byte;
          offset_d = req_addr[1:0];
          fault_d  = (req_addr >= ADDR_LIMIT);
          rdata_d  = 32'h0;
          if (req_addr >= ADDR_LIMIT) begin
            state_d = RESP;
          end else begin
            state_d       = ISSUE;
            mem_address_d = {req_addr[ADDR_W-1:2], 2'b00};
            if (req_write) begin
              if (req_byte) begin
                mem_is_write_d   = lane_onehot(req_addr[1:0]);
                mem_write_data_d = {4{req_wdata[7:0]}};
              end else begin
                mem_is_write_d   = 4'b1111;
                mem_write_data_d = req_wdata;
              end
            end else begin
              mem_is_read_d   = 1'b1;
              mem_byte_read_d = req_byte;
            end
          end
        end
      end
      ISSUE: state_d = write_q ? RESP : WAIT;
      WAIT: begin
        rdata_d = fmt_data;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q          <= IDLE;
      write_q          <= 1'b0;
      byte_q           <= 1'b0;
      fault_q          <= 1'b0;
      offset_q         <= 2'd0;
      rdata_q          <= 32'h0;
      mem_address_q    <= '0;
      mem_is_write_q   <= 4'b0000;
      mem_write_data_q <= 32'h0;
      mem_is_read_q    <= 1'b0;
      mem_byte_read_q  <= 1'b0;
    end else begin
      state_q          <= state_d;
      write_q          <= write_d;
      byte_q           <= byte_d;
      fault_q          <= fault_d;
      offset_q         <= offset_d;
      rdata_q          <= rdata_d;
      mem_address_q    <= mem_address_d;
      mem_is_write_q   <= mem_is_write_d;
      mem_write_data_q <= mem_write_data_d;
      mem_is_read_q    <= mem_is_read_d;
      mem_byte_read_q  <= mem_byte_read_d;
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign resp_valid    = (state_q == RESP);
  assign resp_rdata    = rdata_q;
  assign resp_fault    = fault_q;
  assign mem_address   = mem_address_q;
  assign mem_isWrite   = mem_is_write_q;
  assign mem_writeData = mem_write_data_q;
  assign mem_isRead    = mem_is_read_q;
  assign mem_byteRead  = mem_byte_read_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: byte-addressed memory model, response
// scoreboard checked every RESP cycle, and literal expectations from the test plan.
module tb_mem_access_unit;

  logic        clock;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_byte;
  logic [17:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [17:0] mem_address;
  logic [3:0]  mem_isWrite;
  logic [31:0] mem_writeData;
  logic        mem_isRead;
  logic        mem_byteRead;
  logic [31:0] mem_data;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        fault;
    logic [31:0] rdata;
  } exp_t;

  exp_t        expq[$];
  logic [7:0]  mdl [0:65535];
  logic [31:0] ram [0:16383];
  logic [17:0] last_addr;
  logic [31:0] last_wdata;

  mem_access_unit dut (
    .clock         (clock),
    .resetn        (resetn),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_byte      (req_byte),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_rdata    (resp_rdata),
    .resp_fault    (resp_fault),
    .mem_address   (mem_address),
    .mem_isWrite   (mem_isWrite),
    .mem_writeData (mem_writeData),
    .mem_isRead    (mem_isRead),
    .mem_byteRead  (mem_byteRead),
    .mem_data      (mem_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Registered-read RAM with byte-lane write enables
  always @(posedge clock) begin
    for (int i = 0; i < 4; i++)
      if (mem_isWrite[i]) ram[mem_address[15:2]][8*i +: 8] <= mem_writeData[8*i +: 8];
    if (mem_isRead) mem_data <= ram[mem_address[15:2]];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (resetn && resp_valid) begin
      if (expq.size() == 0) begin
        checkOutput("spurious_resp", 32'(resp_valid), 32'd0);
      end else begin
        checkOutput("resp_rdata", resp_rdata, expq[0].rdata);
        checkOutput("resp_fault", 32'(resp_fault), 32'(expq[0].fault));
      end
    end
  end

  always @(posedge clock) begin
    if (resetn && resp_valid && resp_ready && expq.size() > 0) void'(expq.pop_front());
  end

  task automatic applyStimulus(input logic wr, input logic by, input logic [17:0] addr,
                               input logic [31:0] wdata, input int hold,
                               input logic use_lit, input logic [31:0] lit);
    int          a, base, k, n, strobes, lat;
    logic        flt, seen;
    logic [31:0] exp_rd, exp_wd;
    logic [3:0]  exp_we;
    exp_t        e;
    a    = int'(addr);
    base = a & ~3;
    k    = a & 3;
    flt  = (a >= 65536);
    exp_rd = 32'h0;
    if (!flt && !wr) begin
      if (by) exp_rd = {24'b0, mdl[a]};
      else for (int j = 0; j < 4; j++) exp_rd[8*j +: 8] = mdl[base + ((k + j) % 4)];
    end
    exp_we = 4'b0000;
    exp_wd = last_wdata;
    if (!flt && wr) begin
      if (by) begin
        exp_we = 4'(1 << k);
        exp_wd = {4{wdata[7:0]}};
        mdl[a] = wdata[7:0];
      end else begin
        exp_we = 4'hF;
        exp_wd = wdata;
        for (int j = 0; j < 4; j++) mdl[base + j] = wdata[8*j +: 8];
      end
    end
    lat = flt ? 1 : (wr ? 2 : 3);
    e.fault = flt;
    e.rdata = exp_rd;

    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    checkOutput("req_ready_wait", 32'(req_ready), 32'd1);
    expq.push_back(e);
    req_write  = wr;
    req_byte   = by;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    resp_ready = (hold == 0);
    @(posedge clock);
    #1 req_valid = 1'b0;

    n = 0;
    strobes = 0;
    seen = 1'b0;
    while (!seen && n < 10) begin
      @(negedge clock);
      n++;
      if (mem_isRead || mem_isWrite != 4'b0000 || mem_byteRead) strobes++;
      if (n == 1) begin
        if (flt) begin
          checkOutput("hold_address", 32'(mem_address), 32'(last_addr));
        end else begin
          checkOutput("issue_address", 32'(mem_address), 32'(base));
          checkOutput("issue_byteRead", 32'(mem_byteRead), 32'(!wr && by));
          last_addr = 18'(base);
        end
        checkOutput("issue_isWrite", 32'(mem_isWrite), 32'(exp_we));
        checkOutput("issue_writeData", mem_writeData, exp_wd);
        checkOutput("issue_isRead", 32'(mem_isRead), 32'(!flt && !wr));
        last_wdata = exp_wd;
      end
      if (resp_valid) seen = 1'b1;
    end
    checkOutput("resp_latency", 32'(n), 32'(lat));
    if (use_lit && seen) checkOutput("literal_rdata", resp_rdata, lit);
    checkOutput("strobe_cycles", 32'(strobes), flt ? 32'd0 : 32'd1);

    if (hold > 0) begin
      // Competing request while stalled must be ignored
      req_write = 1'b1;
      req_byte  = 1'b0;
      req_addr  = 18'h00080;
      req_wdata = 32'hBAD0BAD0;
      req_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clock);
        checkOutput("stall_resp_valid", 32'(resp_valid), 32'd1);
        checkOutput("stall_req_ready", 32'(req_ready), 32'd0);
        checkOutput("stall_isWrite", 32'(mem_isWrite), 32'd0);
      end
      resp_ready = 1'b1;
    end
    @(negedge clock);
    req_valid = 1'b0;
    checkOutput("post_handshake_ready", 32'(req_ready), 32'd1);
    checkOutput("post_handshake_valid", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mdl[i] = 8'h00;
    for (int i = 0; i < 16384; i++) ram[i] = 32'h0;
    mem_data   = 32'h0;
    last_addr  = 18'h0;
    last_wdata = 32'h0;
    resetn     = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_byte   = 1'b0;
    req_addr   = 18'h0;
    req_wdata  = 32'h0;
    resp_ready = 1'b1;
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_resp_fault", 32'(resp_fault), 32'd0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
    checkOutput("rst_mem_address", 32'(mem_address), 32'd0);
    checkOutput("rst_mem_isWrite", 32'(mem_isWrite), 32'd0);
    checkOutput("rst_mem_writeData", mem_writeData, 32'd0);
    checkOutput("rst_mem_isRead", 32'(mem_isRead), 32'd0);
    checkOutput("rst_mem_byteRead", 32'(mem_byteRead), 32'd0);

    $display("[TB] word store then load");
    applyStimulus(1'b1, 1'b0, 18'h00010, 32'hDEADBEEF, 0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 18'h00010, 32'h0, 0, 1'b1, 32'hDEADBEEF);

    $display("[TB] byte stores");
    applyStimulus(1'b1, 1'b1, 18'h00021, 32'h0000005A, 0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 18'h00023, 32'hFFFFFFC3, 0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 18'h00020, 32'h0, 0, 1'b1, 32'hC3005A00);

    $display("[TB] byte zero-extend and word rotate");
    applyStimulus(1'b1, 1'b0, 18'h00040, 32'h11223384, 0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 18'h00040, 32'h0, 0, 1'b1, 32'h00000084);
    applyStimulus(1'b0, 1'b1, 18'h00043, 32'h0, 0, 1'b1, 32'h00000011);
    applyStimulus(1'b0, 1'b0, 18'h00041, 32'h0, 0, 1'b1, 32'h84112233);

    $display("[TB] misaligned word store");
    applyStimulus(1'b1, 1'b0, 18'h00053, 32'hA1B2C3D4, 0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 18'h00050, 32'h0, 0, 1'b1, 32'hA1B2C3D4);
    applyStimulus(1'b0, 1'b0, 18'h00052, 32'h0, 0, 1'b1, 32'hC3D4A1B2);

    $display("[TB] faults and range boundary");
    applyStimulus(1'b0, 1'b0, 18'h10000, 32'h0, 0, 1'b1, 32'h00000000);
    applyStimulus(1'b1, 1'b0, 18'h3FFFC, 32'h12345678, 0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 18'h0FFFC, 32'h01020304, 0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 18'h0FFFF, 32'h0, 0, 1'b1, 32'h00000001);

    $display("[TB] backpressure");
    applyStimulus(1'b0, 1'b0, 18'h00040, 32'h0, 5, 1'b1, 32'h11223384);

    $display("[TB] reset during load");
    req_write = 1'b0;
    req_byte  = 1'b0;
    req_addr  = 18'h00010;
    req_valid = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    checkOutput("midrst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("midrst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("midrst_resp_rdata", resp_rdata, 32'd0);
    checkOutput("midrst_mem_address", 32'(mem_address), 32'd0);
    resetn = 1'b1;
    last_addr  = 18'h0;
    last_wdata = 32'h0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      checkOutput("midrst_no_resp", 32'(resp_valid), 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 18'h00010, 32'h0, 0, 1'b1, 32'hDEADBEEF);

    checkOutput("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
